uart_rx_fifo: RTL and testbench

- Receive buffer stage placed directly downstream of the UART serial receiver.
- Consumes the receiver's ready/ack byte handshake and stores bytes in a synchronous FIFO.
- Presents the bytes to the system as a valid/ready stream.
- Holds the receiver off when full, so no accepted byte is ever silently overwritten.

---
 rtl/uart_rx_fifo_pkg.sv | 10 +
 rtl/uart_sync_fifo.sv | 67 ++++++
 rtl/uart_rx_fifo.sv | 81 ++++++++
 tb/tb_uart_rx_fifo.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_rx_fifo_pkg.sv
// Shared definitions for the UART receive buffer: handshake FSM encodings
// and the default byte width.
package uart_rx_fifo_pkg;

  localparam int RXF_DATA_WIDTH = 8;

  localparam logic [0:0] RXF_IDLE = 1'b0;
  localparam logic [0:0] RXF_ACK  = 1'b1;

endpackage

// File: rtl/uart_sync_fifo.sv
// Generic synchronous show-ahead FIFO with push/pop/flush and an explicit
// occupancy counter.
module uart_sync_fifo
  import uart_rx_fifo_pkg::*;
#(
  parameter int DEPTH_LOG2 = 4,
  parameter int DATA_WIDTH = RXF_DATA_WIDTH
) (
  input  logic                  clock_i,
  input  logic                  reset_i,
  input  logic                  push_i,
  input  logic [DATA_WIDTH-1:0] push_data_i,
  input  logic                  pop_i,
  input  logic                  flush_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic [DEPTH_LOG2:0]   count_o,
  output logic                  full_o,
  output logic                  empty_o
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE    = 1;
  localparam logic [DEPTH_LOG2:0]   CNT_ONE    = 1;
  localparam logic [DEPTH_LOG2:0]   FULL_COUNT = {1'b1, {DEPTH_LOG2{1'b0}}};

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q;
  logic [DEPTH_LOG2-1:0] rd_ptr_q;
  logic [DEPTH_LOG2:0]   count_q;
  logic                  do_push;
  logic                  do_pop;

  // Flush wins over both sides; a full FIFO refuses pushes even if popping.
  assign do_push = push_i && !full_o && !flush_i;
  assign do_pop  = pop_i && !empty_o && !flush_i;

  // NOTE: storage has no reset; only pointers and count define its contents.
  always_ff @(posedge clock_i) begin
    if (do_push) begin
      mem[wr_ptr_q] <= push_data_i;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clock_i) begin
    if (reset_i || flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CNT_ONE;
        2'b01:   count_q <= count_q - CNT_ONE;
        default: count_q <= count_q;
      endcase
    end
  end

  assign data_o  = mem[rd_ptr_q];
  assign count_o = count_q;
  assign full_o  = (count_q == FULL_COUNT);
  assign empty_o = (count_q == '0);

endmodule

// File: rtl/uart_rx_fifo.sv
// Receive buffer behind the UART receiver: ready/ack byte handshake in,
// valid/ready stream out, with backpressure and a sticky stall flag.
module uart_rx_fifo
  import uart_rx_fifo_pkg::*;
#(
  parameter int DEPTH_LOG2 = 4,
  parameter int DATA_WIDTH = RXF_DATA_WIDTH
) (
  input  logic                  clock_i,
  input  logic                  reset_i,
  input  logic [DATA_WIDTH-1:0] rx_data_i,
  input  logic                  rx_ready_i,
  output logic                  rx_ack_o,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  valid_o,
  input  logic                  ready_i,
  input  logic                  flush_i,
  output logic [DEPTH_LOG2:0]   count_o,
  output logic                  full_o,
  output logic                  stall_o
);

  logic [0:0] state_q;
  logic [0:0] state_d;
  logic       fifo_full;
  logic       fifo_empty;
  logic       push;
  logic       pop;

  // One push per handshake: ACK blocks further pushes until ready drops.
  assign push = (state_q == RXF_IDLE) && rx_ready_i && !fifo_full && !flush_i;
  assign pop  = !fifo_empty && ready_i && !flush_i;

  uart_sync_fifo #(
    .DEPTH_LOG2 (DEPTH_LOG2),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_fifo (
    .clock_i     (clock_i),
    .reset_i     (reset_i),
    .push_i      (push),
    .push_data_i (rx_data_i),
    .pop_i       (pop),
    .flush_i     (flush_i),
    .data_o      (data_o),
    .count_o     (count_o),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty)
  );

  // NOTE: next-state gets a default first so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      RXF_IDLE: if (push)        state_d = RXF_ACK;
      RXF_ACK:  if (!rx_ready_i) state_d = RXF_IDLE;
    endcase
  end

  // Flush leaves the FSM alone so an in-flight handshake still completes.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q <= RXF_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clock_i) begin
    if (reset_i || flush_i) begin
      stall_o <= 1'b0;
    end else if (rx_ready_i && fifo_full) begin
      stall_o <= 1'b1;
    end
  end

  assign rx_ack_o = (state_q == RXF_ACK);
  assign valid_o  = !fifo_empty;
  assign full_o   = fifo_full;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo at DEPTH_LOG2=2: directed receiver
// handshakes feed an expected-byte queue that a negedge monitor drains.
module tb_uart_rx_fifo;

  logic       clock_i = 1'b0;
  logic       reset_i = 1'b1;
  logic [7:0] rx_data_i = '0;
  logic       rx_ready_i = 1'b0;
  logic       rx_ack_o;
  logic [7:0] data_o;
  logic       valid_o;
  logic       ready_i = 1'b0;
  logic       flush_i = 1'b0;
  logic [2:0] count_o;
  logic       full_o;
  logic       stall_o;

  int         checks = 0;
  int         failures = 0;
  int         max_count = 0;
  logic [7:0] exp_q[$];

  always #5 clock_i = ~clock_i;

  uart_rx_fifo #(
    .DEPTH_LOG2 (2),
    .DATA_WIDTH (8)
  ) dut (
    .clock_i    (clock_i),
    .reset_i    (reset_i),
    .rx_data_i  (rx_data_i),
    .rx_ready_i (rx_ready_i),
    .rx_ack_o   (rx_ack_o),
    .data_o     (data_o),
    .valid_o    (valid_o),
    .ready_i    (ready_i),
    .flush_i    (flush_i),
    .count_o    (count_o),
    .full_o     (full_o),
    .stall_o    (stall_o)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock_i);
    #1;
  endtask

  // Receiver model: present a byte, wait for ack, drop ready, wait for ack low.
  task automatic send_byte(input logic [7:0] b);
    exp_q.push_back(b);
    rx_data_i  = b;
    rx_ready_i = 1'b1;
    for (int i = 0; i < 50 && !rx_ack_o; i++) tick();
    if (!rx_ack_o) check("ack_rise_timeout", 32'(rx_ack_o), 1);
    rx_ready_i = 1'b0;
    for (int i = 0; i < 50 && rx_ack_o; i++) tick();
    if (rx_ack_o) check("ack_fall_timeout", 32'(rx_ack_o), 0);
  endtask

  // Monitor: a pop happens on the next edge whenever valid && ready here.
  initial begin
    forever begin
      @(negedge clock_i);
      if (32'(count_o) > max_count) max_count = 32'(count_o);
      if (!reset_i && !flush_i && valid_o && ready_i) begin
        if (exp_q.size() == 0) begin
          check("unexpected_pop", 32'(data_o), 32'hFFFF_FFFF);
        end else begin
          check("pop_data", 32'(data_o), 32'(exp_q.pop_front()));
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    tick();
    tick();
    check("rst_ack", 32'(rx_ack_o), 0);
    check("rst_valid", 32'(valid_o), 0);
    check("rst_count", 32'(count_o), 0);
    check("rst_full", 32'(full_o), 0);
    check("rst_stall", 32'(stall_o), 0);
    reset_i = 1'b0;
    tick();

    // Single byte, ready dropped two cycles after ack rises.
    exp_q.push_back(8'hA5);
    rx_data_i  = 8'hA5;
    rx_ready_i = 1'b1;
    tick();
    check("single_ack_n1", 32'(rx_ack_o), 1);
    check("single_valid", 32'(valid_o), 1);
    check("single_data", 32'(data_o), 32'hA5);
    check("single_count", 32'(count_o), 1);
    tick();
    check("single_ack_n2", 32'(rx_ack_o), 1);
    tick();
    check("single_ack_n3", 32'(rx_ack_o), 1);
    rx_ready_i = 1'b0;
    tick();
    check("single_ack_low", 32'(rx_ack_o), 0);
    check("single_count_hold", 32'(count_o), 1);
    ready_i = 1'b1;
    tick();
    ready_i = 1'b0;
    check("single_pop_count", 32'(count_o), 0);
    check("single_pop_valid", 32'(valid_o), 0);

    // Fill to full, then backpressure a fifth byte.
    for (int i = 1; i <= 4; i++) send_byte(8'(i));
    check("fill_full", 32'(full_o), 1);
    check("fill_count", 32'(count_o), 4);
    check("fill_stall_clear", 32'(stall_o), 0);
    exp_q.push_back(8'h05);
    rx_data_i  = 8'h05;
    rx_ready_i = 1'b1;
    tick();
    check("full_no_ack", 32'(rx_ack_o), 0);
    check("full_stall", 32'(stall_o), 1);
    check("full_count", 32'(count_o), 4);
    ready_i = 1'b1;
    tick();
    ready_i = 1'b0;
    check("full_pop_count", 32'(count_o), 3);
    check("full_pop_no_ack", 32'(rx_ack_o), 0);
    tick();
    check("late_push_ack", 32'(rx_ack_o), 1);
    check("late_push_count", 32'(count_o), 4);
    rx_ready_i = 1'b0;
    tick();
    check("late_push_ack_low", 32'(rx_ack_o), 0);
    ready_i = 1'b1;
    repeat (4) tick();
    ready_i = 1'b0;
    check("drain_count", 32'(count_o), 0);
    check("drain_valid", 32'(valid_o), 0);
    check("stall_sticky", 32'(stall_o), 1);

    // Wrap: stream through the small FIFO with the consumer always ready.
    max_count = 0;
    ready_i   = 1'b1;
    for (int i = 0; i < 10; i++) send_byte(8'(8'h10 + i));
    tick();
    ready_i = 1'b0;
    check("wrap_max_count", 32'(max_count), 1);
    check("wrap_count", 32'(count_o), 0);
    check("wrap_all_read", 32'(exp_q.size()), 0);

    // Simultaneous push and pop at count 2.
    send_byte(8'h20);
    send_byte(8'h21);
    check("simul_pre_count", 32'(count_o), 2);
    exp_q.push_back(8'h22);
    rx_data_i  = 8'h22;
    rx_ready_i = 1'b1;
    ready_i    = 1'b1;
    tick();
    ready_i    = 1'b0;
    rx_ready_i = 1'b0;
    check("simul_count", 32'(count_o), 2);
    check("simul_ack", 32'(rx_ack_o), 1);
    check("simul_head", 32'(data_o), 32'h21);
    tick();
    check("simul_ack_low", 32'(rx_ack_o), 0);

    // Flush during ACK with three stored bytes.
    check("pre_flush_stall", 32'(stall_o), 1);
    exp_q.push_back(8'h23);
    rx_data_i  = 8'h23;
    rx_ready_i = 1'b1;
    tick();
    check("pre_flush_count", 32'(count_o), 3);
    check("pre_flush_ack", 32'(rx_ack_o), 1);
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    exp_q.delete();
    check("flush_count", 32'(count_o), 0);
    check("flush_valid", 32'(valid_o), 0);
    check("flush_stall", 32'(stall_o), 0);
    check("flush_ack_held", 32'(rx_ack_o), 1);
    rx_ready_i = 1'b0;
    tick();
    check("flush_ack_low", 32'(rx_ack_o), 0);
    send_byte(8'h7E);
    check("post_flush_data", 32'(data_o), 32'h7E);
    ready_i = 1'b1;
    tick();
    ready_i = 1'b0;
    check("post_flush_count", 32'(count_o), 0);

    // Reset in the middle of a handshake.
    send_byte(8'h30);
    exp_q.push_back(8'h31);
    rx_data_i  = 8'h31;
    rx_ready_i = 1'b1;
    tick();
    check("pre_rst_count", 32'(count_o), 2);
    check("pre_rst_ack", 32'(rx_ack_o), 1);
    reset_i = 1'b1;
    tick();
    reset_i = 1'b0;
    exp_q.delete();
    check("mid_rst_ack", 32'(rx_ack_o), 0);
    check("mid_rst_count", 32'(count_o), 0);
    check("mid_rst_valid", 32'(valid_o), 0);
    exp_q.push_back(8'h31);
    tick();
    check("fresh_push_ack", 32'(rx_ack_o), 1);
    check("fresh_push_count", 32'(count_o), 1);
    check("fresh_push_data", 32'(data_o), 32'h31);
    rx_ready_i = 1'b0;
    tick();
    check("fresh_ack_low", 32'(rx_ack_o), 0);
    ready_i = 1'b1;
    tick();
    ready_i = 1'b0;
    check("final_count", 32'(count_o), 0);
    check("scoreboard_empty", 32'(exp_q.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
